alu_io_sequencer: RTL and testbench

ALU_IO_SEQUENCER -- requirements
Module: alu_io_sequencer

---
 rtl/alu_io_sequencer.sv | 110 +++++++++++
 tb/tb_alu_io_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_io_sequencer.sv
// Request/response front end for an ALU.
// It holds the operands, issues a start pulse, waits for done with a timeout, and presents one response.
module alu_io_sequencer #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic [7:0]  operand1,
  output logic [7:0]  operand2,
  output logic [1:0]  op_sel,
  output logic        start,
  input  logic        done,
  input  logic [15:0] outbus,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_div0,
  output logic        rsp_timeout,
  output logic [7:0]  rsp_cycles,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and the payload is held while valid is high.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0] state;
  logic [7:0] counter;
  logic [7:0] cnt_next;
  logic       timeout_hit;

  assign cnt_next    = (counter == 8'hFF) ? 8'hFF : counter + 8'd1;
  assign timeout_hit = ({1'b0, counter} + 9'd1) >= {1'b0, TIMEOUT_CYCLES};

  assign req_ready = (state == S_IDLE);
  assign start     = (state == S_ISSUE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      counter     <= 8'd0;
      operand1    <= 8'd0;
      operand2    <= 8'd0;
      op_sel      <= 2'd0;
      rsp_result  <= 16'd0;
      rsp_div0    <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_cycles  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            operand1 <= req_a;
            operand2 <= req_b;
            op_sel   <= req_op;
            // Division by zero is answered locally; the data path is never started.
            if (req_op == 2'b11 && req_b == 8'd0) begin
              rsp_result  <= 16'hFFFF;
              rsp_div0    <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_cycles  <= 8'd0;
              state       <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          counter <= 8'd0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a timeout landing on the same cycle.
          if (done) begin
            rsp_result  <= outbus;
            rsp_div0    <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_cycles  <= cnt_next;
            state       <= S_RESP;
          end else if (timeout_hit) begin
            rsp_result  <= 16'd0;
            rsp_div0    <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_cycles  <= TIMEOUT_CYCLES;
            state       <= S_RESP;
          end else begin
            counter <= cnt_next;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_io_sequencer.sv
// Bench for alu_io_sequencer: directed vector table, random transactions against a reference model,
// and hand-written reset/backpressure sequences.
module tb_alu_io_sequencer;
  localparam int T = 10;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a, req_b;
  logic [7:0]  operand1, operand2;
  logic [1:0]  op_sel;
  logic        start, done;
  logic [15:0] outbus;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_div0, rsp_timeout;
  logic [7:0]  rsp_cycles;
  logic        busy;
  logic [1:0]  state_dbg;

  alu_io_sequencer #(.TIMEOUT_CYCLES(8'(T))) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .operand1(operand1), .operand2(operand2), .op_sel(op_sel),
    .start(start), .done(done), .outbus(outbus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_div0(rsp_div0), .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [25:0] exp_q[$];  // {timeout, div0, cycles, result}

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a, b;
    int          lat;     // cycles from start to done; 0 = never
    logic [15:0] out;
    int          hold;    // cycles rsp_ready is held low
    logic [15:0] e_res;
    logic        e_div0, e_to;
    logic [7:0]  e_cyc;
    int          e_lat;   // cycles from acceptance+1 to rsp_valid
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outcome derived from the rules, not the state machine.
  function automatic void model(input logic [1:0] op, input logic [7:0] b, input int lat,
                                input logic [15:0] out, output logic [25:0] rsp, output int vlat);
    if (op == 2'b11 && b == 8'd0) begin
      rsp = {1'b0, 1'b1, 8'd0, 16'hFFFF};
      vlat = 0;
    end else if (lat != 0 && lat <= T) begin
      rsp = {1'b0, 1'b0, 8'(lat), out};
      vlat = lat + 1;
    end else begin
      rsp = {1'b1, 1'b0, 8'(T), 16'h0000};
      vlat = T + 1;
    end
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, 32'(state_dbg), 32'd0);
    check({tag, " operands"}, {14'd0, operand1, operand2, op_sel}, 32'd0);
    check({tag, " rsp"}, {6'd0, rsp_timeout, rsp_div0, rsp_cycles, rsp_result}, 32'd0);
    check({tag, " ctrl"}, {28'd0, start, rsp_valid, busy, req_ready}, 32'd1);
  endtask

  // Driver: one full transaction with a behavioural control unit answering start.
  task automatic run_txn(input string name, input logic [1:0] op, input logic [7:0] a, b,
                         input int lat, input logic [15:0] out, input int hold,
                         input logic [25:0] exp_rsp, input int exp_lat);
    int since, starts, k;
    bit started, got;
    logic [25:0] cap, exp;
    exp_q.push_back(exp_rsp);
    @(negedge clk);
    check({name, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    check({name, " operands"}, {14'd0, operand1, operand2, op_sel}, {14'd0, a, b, op});
    check({name, " req_ready busy"}, {30'd0, req_ready, busy}, 32'd1);
    started = 0; since = 0; starts = 0; got = 0;
    for (k = 0; k < 60; k++) begin
      if (rsp_valid) begin got = 1; break; end
      if (start) begin starts++; started = 1; since = 0; end
      else if (started) since++;
      if (started && lat != 0 && since == lat) begin done = 1'b1; outbus = out; end
      else begin done = 1'b0; outbus = 16'($urandom); end
      @(negedge clk);
    end
    done = 1'b0;
    check({name, " rsp_valid seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(k), 32'(exp_lat));
    check({name, " starts"}, 32'(starts), (exp_rsp[24]) ? 32'd0 : 32'd1);
    cap = {rsp_timeout, rsp_div0, rsp_cycles, rsp_result};
    exp = exp_q.pop_front();
    check({name, " response"}, 32'(cap), 32'(exp));
    // Backpressure: response must hold, no new request taken, done ignored.
    for (int j = 0; j < hold; j++) begin
      req_valid = 1'b1; req_a = ~a; done = 1'($urandom); outbus = 16'($urandom);
      @(negedge clk);
      check({name, " hold"}, {4'd0, req_ready, rsp_valid, rsp_timeout, rsp_div0, rsp_cycles, rsp_result},
            {4'd0, 1'b0, 1'b1, cap});
      check({name, " hold operand1"}, 32'(operand1), 32'(a));
    end
    done = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_a = ~a;
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    check({name, " after handshake"}, {4'd0, req_ready, rsp_valid, rsp_timeout, rsp_div0, rsp_cycles, rsp_result},
          {4'd0, 1'b1, 1'b0, cap});
    check({name, " no accept in handshake"}, 32'(operand1), 32'(a));
  endtask

  initial begin
    logic [25:0] m_rsp;
    int m_lat, lat, hold;
    logic [1:0] op;
    logic [7:0] a, b;
    logic [15:0] out;

    vecs[0] = '{2'b00, 8'd25,  8'd17,  3,  16'h002A, 0, 16'h002A, 1'b0, 1'b0, 8'd3,  4};
    vecs[1] = '{2'b11, 8'h90,  8'h00,  3,  16'h1111, 0, 16'hFFFF, 1'b1, 1'b0, 8'd0,  0};
    vecs[2] = '{2'b10, 8'h90,  8'h05,  4,  16'hFD00, 5, 16'hFD00, 1'b0, 1'b0, 8'd4,  5};
    vecs[3] = '{2'b00, 8'h01,  8'h02,  0,  16'h0003, 1, 16'h0000, 1'b0, 1'b1, 8'd10, 11};
    vecs[4] = '{2'b01, 8'h50,  8'h20,  10, 16'h1234, 0, 16'h1234, 1'b0, 1'b0, 8'd10, 11};
    vecs[5] = '{2'b11, 8'h64,  8'h07,  1,  16'h000E, 2, 16'h000E, 1'b0, 1'b0, 8'd1,  2};
    vecs[6] = '{2'b10, 8'h03,  8'h04,  11, 16'h000C, 0, 16'h0000, 1'b0, 1'b1, 8'd10, 11};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_a = 8'd0; req_b = 8'd0;
    done = 1'b0; outbus = 16'd0; rsp_ready = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].out,
              vecs[i].hold, {vecs[i].e_to, vecs[i].e_div0, vecs[i].e_cyc, vecs[i].e_res}, vecs[i].e_lat);

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      lat = $urandom_range(0, 12);
      out = 16'($urandom);
      hold = $urandom_range(0, 3);
      model(op, b, lat, out, m_rsp, m_lat);
      run_txn($sformatf("rnd%0d", i), op, a, b, lat, out, hold, m_rsp, m_lat);
    end

    // Reset two cycles into WAIT, then a late done must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 8'd9; req_b = 8'd4;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid start", 32'(start), 32'd1);
    repeat (2) @(negedge clk);
    check("rst_mid in wait", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid async");
    @(negedge clk);
    rst = 1'b0; done = 1'b1; outbus = 16'hBEEF;
    @(negedge clk);
    done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_mid after%0d", j), {29'd0, rsp_valid, start, busy}, 32'd0);
      @(negedge clk);
    end
    check_reset_values("rst_mid final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
